// File: rtl/mips_muldiv_if.sv
// Issue/result bundle between the EX stage and the HI/LO mul/div unit.
// master: EX-side issuer (start/op/a/b/flush/rd_req/wr_*); slave: mips_muldiv.
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             rd_req;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div0;
  logic             stall;

  modport master (
    output start, op, a, b, flush,
    output rd_req, wr_hi, wr_lo, wr_data,
    input  hi, lo, busy, done, div0, stall
  );

  modport slave (
    input  start, op, a, b, flush,
    input  rd_req, wr_hi, wr_lo, wr_data,
    output hi, lo, busy, done, div0, stall
  );
endinterface

// File: rtl/mips_muldiv.sv
// Multi-cycle MULT/DIV unit owning HI/LO; one bit per cycle, WIDTH+1 latency.
// Ports: clk, reset (sync, active-low), bus (mips_muldiv_if.slave).
// Define MULDIV_SIGNED_EN to honour op[0] (signed ops); otherwise all unsigned.
module mips_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input logic          clk,
  input logic          reset,
  mips_muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam int W2 = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Multiply: upper half accumulates, multiplier shifts out of the low half.
  assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: dividend shifts out of acc low half, quotient bits shift in.
  // Bit WIDTH of the difference is the borrow (restore when set).
  assign div_sh   = {rem_q, acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};

`ifdef MULDIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q, neg_d;
  logic rneg_q, rneg_d;

  assign a_neg = bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = bus.op[0] & bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  always_comb begin
    neg_d  = neg_q;
    rneg_d = rneg_q;
    if (accept) begin
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
    end
  end

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0]
                          : acc_q[WIDTH-1:0];
  // On divide-by-zero rem_q holds |a|; negating by the
  // dividend sign gives back the raw a.
  assign rem_fix  = rneg_q ? -rem_q : rem_q;
`else
  logic unused_op0;

  assign unused_op0 = bus.op[0];
  assign a_mag      = bus.a;
  assign b_mag      = bus.b;
  assign prod_fix   = acc_q;
  assign quo_fix    = acc_q[WIDTH-1:0];
  assign rem_fix    = rem_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = div0_q;
    accept   = 1'b0;

    // MTHI/MTLO land only while idle; a result written later wins.
    if (!busy_q) begin
      if (bus.wr_hi) hi_d = bus.wr_data;
      if (bus.wr_lo) lo_d = bus.wr_data;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept   = 1'b1;
          state_d  = RUN;
          busy_d   = 1'b1;
          cnt_d    = CNT_INIT;
          div0_d   = 1'b0;
          is_div_d = bus.op[1];
          bzero_d  = (bus.b == '0);
          rem_d    = '0;
          opnd_d   = bus.op[1] ? b_mag : a_mag;
          acc_d    = {{WIDTH{1'b0}},
                      (bus.op[1] ? a_mag : b_mag)};
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = FIN;
          unique case (1'b1)
            is_div_q: begin
              acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0],
                                  ~div_diff[WIDTH]};
              rem_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0]
                                      : div_diff[WIDTH-1:0];
            end
            default: begin
              acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
          endcase
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d   = bzero_q ? '1 : quo_fix;
            hi_d   = rem_fix;
            div0_d = bzero_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.div0  = div0_q;
  assign bus.stall = busy_q & (bus.start | bus.rd_req
                             | bus.wr_hi | bus.wr_lo);

endmodule
